// File: rtl/bram36_pkg.sv
// Shared constants and state type for the 36-entry symbol frame buffer controller.
package bram36_pkg;
    localparam int DEPTH  = 36;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 13;

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;
endpackage

// File: rtl/bram36_frame_ctrl_if.sv
// Stream and BRAM-port bundle between the frame controller and its surroundings.
interface bram36_frame_ctrl_if;
    import bram36_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              rev_order;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              frame_done;
    logic              busy;
    logic              bram_write_en;
    logic [ADDR_W-1:0] bram_write_addr;
    logic [DATA_W-1:0] bram_write_data;
    logic              bram_read_en;
    logic [ADDR_W-1:0] bram_read_addr;
    logic [DATA_W-1:0] bram_read_data;

    // The controller is the slave; whoever feeds samples and hosts the BRAM is the master.
    modport master (
        output in_valid, in_data, rev_order, out_ready, bram_read_data,
        input  in_ready, out_valid, out_data, frame_done, busy,
        input  bram_write_en, bram_write_addr, bram_write_data,
        input  bram_read_en, bram_read_addr
    );

    modport slave (
        input  in_valid, in_data, rev_order, out_ready, bram_read_data,
        output in_ready, out_valid, out_data, frame_done, busy,
        output bram_write_en, bram_write_addr, bram_write_data,
        output bram_read_en, bram_read_addr
    );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs BRAM read data while the downstream stalls.
module skid_fifo2 #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            if (push_ok && !pop_ok)      count <= count + 2'd1;
            else if (!push_ok && pop_ok) count <= count - 2'd1;
        end
    end

    // Storage is not reset; an empty FIFO presents zero instead of stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/bram36_frame_ctrl.sv
// Store-then-forward controller: fills the 36-entry BRAM from the input stream, then drains it.
module bram36_frame_ctrl
    import bram36_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    bram36_frame_ctrl_if.slave  bus
);
    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic              rev_q;
    logic              inflight;
    logic              wr_fire;
    logic              wr_last;
    logic              pop;
    logic              issue;
    logic              last_pop;
    logic [1:0]        skid_count;
    logic [DATA_W-1:0] skid_head;
    logic [2:0]        occ_after;

    skid_fifo2 #(.WIDTH(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.bram_read_data),
        .pop       (pop),
        .count     (skid_count),
        .head      (skid_head)
    );

    assign wr_fire = bus.in_valid && (state == FILL);
    assign wr_last = wr_fire && (wr_cnt == ADDR_W'(DEPTH - 1));
    assign pop     = (skid_count != 2'd0) && bus.out_ready;

    // A read is only issued if its data is guaranteed a skid slot, counting the one in flight.
    assign occ_after = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == DRAIN) && (rd_cnt < ADDR_W'(DEPTH)) && (occ_after < 3'd2);
    assign last_pop  = (state == DRAIN) && pop && (rd_cnt == ADDR_W'(DEPTH)) &&
                       !inflight && (skid_count == 2'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (wr_last)  state_nx = DRAIN;
            DRAIN:   if (last_pop) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rev_q    <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (wr_fire) begin
                if (wr_last) begin
                    wr_cnt <= '0;
                    rev_q  <= bus.rev_order;
                end else begin
                    wr_cnt <= wr_cnt + ADDR_W'(1);
                end
            end
            if (last_pop)   rd_cnt <= '0;
            else if (issue) rd_cnt <= rd_cnt + ADDR_W'(1);
        end
    end

    assign bus.in_ready        = (state == FILL);
    assign bus.busy            = (state == DRAIN);
    assign bus.bram_write_en   = wr_fire;
    assign bus.bram_write_addr = wr_cnt;
    assign bus.bram_write_data = bus.in_data;
    assign bus.bram_read_en    = issue;
    assign bus.bram_read_addr  = rev_q ? (ADDR_W'(DEPTH - 1) - rd_cnt) : rd_cnt;
    assign bus.out_valid       = (skid_count != 2'd0);
    assign bus.out_data        = skid_head;
    assign bus.frame_done      = last_pop;
endmodule

// File: tb/tb_bram36_frame_ctrl.sv
// Self-checking bench: BRAM model, frame-level scoreboard, table of frame scenarios plus reset sequences.
module tb_bram36_frame_ctrl;
    import bram36_pkg::*;

    logic clk = 1'b0;
    logic rst;

    bram36_frame_ctrl_if bus ();

    bram36_frame_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: registered read, zero output when not reading.
    logic [DATA_W-1:0] bram_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.bram_write_en && (int'(bus.bram_write_addr) < DEPTH))
            bram_mem[bus.bram_write_addr] <= bus.bram_write_data;
        if (bus.bram_read_en && (int'(bus.bram_read_addr) < DEPTH))
            bus.bram_read_data <= bram_mem[bus.bram_read_addr];
        else
            bus.bram_read_data <= '0;
    end

    typedef struct {
        bit rev;
        int base;
        bit gap;
        int mode;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t vecs [6];

    int checks = 0;
    int errors = 0;

    // Frame-level reference model state.
    int  wr_q [$];
    int  exp_q [$];
    bit  m_drain;
    bit  tb_rev;
    int  issued;
    int  popped;
    int  outstanding;
    int  drain_age;
    int  first_val;
    int  last_val;
    bit  last_wr;
    bit  last_pop;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearModel();
        wr_q.delete();
        exp_q.delete();
        m_drain     = 1'b0;
        tb_rev      = 1'b0;
        issued      = 0;
        popped      = 0;
        outstanding = 0;
        drain_age   = 0;
        last_wr     = 1'b0;
        last_pop    = 1'b0;
    endtask

    // One clock cycle: observe at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        bit wr;
        bit pop;
        int exp_addr;
        wr  = 1'b0;
        pop = 1'b0;
        @(negedge clk);
        if (!rst) begin
            wr = bus.in_valid && !m_drain;
            checkOutput("in_ready", int'(bus.in_ready), int'(!m_drain));
            checkOutput("busy", int'(bus.busy), int'(m_drain));
            checkOutput("wr_en", int'(bus.bram_write_en), int'(wr));
            if (wr) begin
                checkOutput("wr_addr", int'(bus.bram_write_addr), wr_q.size());
                checkOutput("wr_data", int'(bus.bram_write_data), int'(bus.in_data));
                wr_q.push_back(int'(bus.in_data));
            end
            if (m_drain) begin
                if (bus.bram_read_en) begin
                    if (issued >= DEPTH) begin
                        checkOutput("extra_read", int'(bus.bram_read_en), 0);
                    end else begin
                        exp_addr = tb_rev ? (DEPTH - 1 - issued) : issued;
                        checkOutput("rd_addr", int'(bus.bram_read_addr), exp_addr);
                    end
                    issued++;
                    outstanding++;
                end
                if (drain_age < 2)
                    checkOutput("early_valid", int'(bus.out_valid), 0);
                else if (drain_age == 2)
                    checkOutput("first_valid_latency", int'(bus.out_valid), 1);
                pop = bus.out_valid && bus.out_ready;
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_pop", int'(bus.out_valid), 0);
                    end else begin
                        checkOutput("out_data", int'(bus.out_data), exp_q.pop_front());
                        popped++;
                        if (popped == 1) first_val = int'(bus.out_data);
                        last_val = int'(bus.out_data);
                    end
                    outstanding--;
                end
                checkOutput("occupancy_le2", int'(outstanding <= 2), 1);
                checkOutput("frame_done", int'(bus.frame_done), int'(pop && popped == DEPTH));
                drain_age++;
                if (pop && popped == DEPTH) begin
                    m_drain = 1'b0;
                    exp_q.delete();
                end
            end else begin
                checkOutput("idle_out_valid", int'(bus.out_valid), 0);
                checkOutput("idle_rd_en", int'(bus.bram_read_en), 0);
                checkOutput("idle_frame_done", int'(bus.frame_done), 0);
            end
            if (wr && wr_q.size() == DEPTH) begin
                tb_rev = bus.rev_order;
                for (int i = 0; i < DEPTH; i++)
                    exp_q.push_back(tb_rev ? wr_q[DEPTH - 1 - i] : wr_q[i]);
                wr_q.delete();
                m_drain     = 1'b1;
                drain_age   = 0;
                issued      = 0;
                popped      = 0;
                outstanding = 0;
            end
        end
        last_wr  = wr;
        last_pop = pop;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset, checked before any clock edge can act.
    task automatic doReset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rev_order = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #2;
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_data", int'(bus.out_data), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_frame_done", int'(bus.frame_done), 0);
        checkOutput("rst_wr_en", int'(bus.bram_write_en), 0);
        checkOutput("rst_wr_addr", int'(bus.bram_write_addr), 0);
        checkOutput("rst_rd_en", int'(bus.bram_read_en), 0);
        checkOutput("rst_rd_addr", int'(bus.bram_read_addr), 0);
        clearModel();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic writeFrame(input int base, input bit rev, input bit gap, input int nwrites);
        int sent;
        sent = 0;
        for (int k = 0; k < 400 && sent < nwrites; k++) begin
            bus.in_valid  = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data   = bus.in_valid ? DATA_W'(base + sent) : DATA_W'($urandom);
            bus.rev_order = (sent == DEPTH - 1 && bus.in_valid) ? rev : 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            if (k == 0 && !gap) checkOutput("first_accept", int'(last_wr), 1);
            if (last_wr) sent++;
        end
        if (sent < nwrites) begin
            checks++;
            errors++;
            $display("[TB] FAIL write_timeout got %0d expected %0d", sent, nwrites);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drainFrame(input int mode, input int max_pops);
        int  pops;
        bit  reached;
        pops    = 0;
        reached = 1'b0;
        for (int k = 0; k < 600 && !reached; k++) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (k % 2 == 0);
                2:       bus.out_ready = (k < 10) ? (k % 2 == 0) : (k >= 20);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = DATA_W'($urandom);
            bus.rev_order = 1'($urandom_range(0, 1));
            tick();
            if (last_pop) pops++;
            if (pops >= max_pops) reached = 1'b1;
        end
        if (!reached) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout got %0d expected %0d", pops, max_pops);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        writeFrame(v.base, v.rev, v.gap, DEPTH);
        drainFrame(v.mode, DEPTH);
        checkOutput("frame_first", first_val, v.exp_first);
        checkOutput("frame_last", last_val, v.exp_last);
        checkOutput("frame_count", popped, DEPTH);
    endtask

    initial begin
        vecs[0] = '{rev: 1'b0, base: 0,    gap: 1'b0, mode: 0, exp_first: 0,    exp_last: 35};
        vecs[1] = '{rev: 1'b1, base: 100,  gap: 1'b0, mode: 0, exp_first: 135,  exp_last: 100};
        vecs[2] = '{rev: 1'b0, base: 300,  gap: 1'b0, mode: 2, exp_first: 300,  exp_last: 335};
        vecs[3] = '{rev: 1'b0, base: 400,  gap: 1'b1, mode: 3, exp_first: 400,  exp_last: 435};
        vecs[4] = '{rev: 1'b1, base: 8000, gap: 1'b1, mode: 1, exp_first: 8035, exp_last: 8000};
        vecs[5] = '{rev: 1'b0, base: 500,  gap: 1'b0, mode: 0, exp_first: 500,  exp_last: 535};

        doReset();

        for (int i = 0; i < 6; i++) begin
            $display("[TB] frame scenario %0d", i);
            applyStimulus(vecs[i]);
        end

        $display("[TB] reset after 20 writes");
        writeFrame(900, 1'b0, 1'b0, 20);
        doReset();

        $display("[TB] reset after 10 drained samples");
        writeFrame(600, 1'b1, 1'b0, DEPTH);
        drainFrame(0, 10);
        doReset();

        applyStimulus('{rev: 1'b0, base: 200, gap: 1'b0, mode: 0, exp_first: 200, exp_last: 235});

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram36_frame_ctrl.md
Name: bram36_frame_ctrl

Overview:
- Controller sequencing the 36-entry x 13-bit symbol BRAM (1-cycle registered read; read_data forced to 0 when read_en low) as a store-then-forward frame buffer.
- Accepts one 36-sample frame on a valid/ready input stream, writes it to the BRAM, then drains it on a valid/ready output stream in natural or reversed address order.
- Sits between subcarrier mapping and the IFFT/antenna stream stages of the MIMO-OFDM datapath; the BRAM is instantiated outside this block.

Parameters:
- DEPTH, 36, samples per frame (BRAM entries)
- ADDR_W, 6, BRAM address width
- DATA_W, 13, sample width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_data  in  DATA_W  input sample
- in_ready  out  1  high only in FILL
- rev_order  in  1  drain order select, sampled at FILL->DRAIN transition
- out_valid  out  1  output sample valid
- out_data  out  DATA_W  output sample
- out_ready  in  1  downstream accept
- frame_done  out  1  one-cycle pulse after last sample accepted downstream
- busy  out  1  high in DRAIN
- bram_write_en  out  1  to BRAM write_en
- bram_write_addr  out  ADDR_W  to BRAM write_addr
- bram_write_data  out  DATA_W  to BRAM write_data
- bram_read_en  out  1  to BRAM read_en
- bram_read_addr  out  ADDR_W  to BRAM read_addr
- bram_read_data  in  DATA_W  from BRAM read_data

Behaviour:
- Reset (async, any state, mid-frame included): state=FILL, wr_cnt=0, rd_cnt=0, in-flight=0, skid empty. All outputs 0 except in_ready=1. Partial frame discarded; BRAM contents not cleared.
- BRAM write and read ports are combinational from registered state: write_en=in_valid&in_ready, write_addr=wr_cnt, write_data=in_data.
- FILL: each in_valid&in_ready writes in_data at wr_cnt, then wr_cnt++. On write with wr_cnt==DEPTH-1: wr_cnt<=0, latch rev_order into rev_q, next state DRAIN. in_ready=0 from the next cycle.
- DRAIN: issue read when rd_cnt<DEPTH and (skid_count + inflight) < 2 after this cycle's pop. bram_read_addr = rev_q ? DEPTH-1-rd_cnt : rd_cnt. Each issue: rd_cnt++, inflight<=1.
- Read data arrives the cycle after issue and is pushed into the 2-entry skid FIFO when inflight==1. bram_read_data is never sampled otherwise, because the BRAM outputs 0 when idle.
- out_valid = skid not empty; out_data = skid head. A pop occurs on out_valid&out_ready.
- Throughput: 1 sample/cycle with out_ready held high. First out_valid appears 2 cycles after entering DRAIN.
- Back-pressure: out_ready low for any duration loses and duplicates nothing. Skid occupancy + inflight never exceeds 2.
- Drain end: after the 36th pop, frame_done=1 for one cycle, rd_cnt<=0, state FILL, in_ready=1 the next cycle. No overlap between FILL and DRAIN.
- busy = (state==DRAIN).
- Simultaneous push and pop on the skid: occupancy unchanged and order preserved.
- rev_order changes outside the FILL->DRAIN edge are ignored.

Decomposition:
- Package bram36_pkg: DEPTH, ADDR_W, DATA_W constants; state enum {FILL, DRAIN}.
- One sub-module, skid_fifo2: 2-entry DATA_W FIFO with push, pop, count, head, and async active-high reset. The controller FSM, counters and address mux stay top-level.

Test Plan:
- Natural order: write 0..35 with in_valid held high, out_ready=1 -> in_ready low after the 36th accept; out_data 0..35 on 36 consecutive cycles starting 2 cycles after DRAIN entry; frame_done pulses once.
- Reverse order: rev_order=1 at the last write, data 100..135 -> output 135 down to 100; a rev_order toggle during DRAIN has no effect.
- Back-pressure: out_ready toggles 1010... then is held low for 10 cycles mid-drain -> exactly 36 samples in order, no repeats; bram_read_en never issues while skid+inflight==2.
- Input gaps: in_valid randomly low 50% -> BRAM writes only on handshakes, addresses 0..35 contiguous; frame then drains correctly.
- Reset mid-operation: assert rst after 20 writes, and again after 10 drained samples -> outputs 0, in_ready=1; the next full frame of 200..235 drains as 200..235.
- Back-to-back frames: two frames sent consecutively with out_ready=1 -> second-frame writes start the cycle after the first frame_done; no input is accepted during DRAIN.
